ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset) onto the open-drain PS/2 clock/data pair and checks the device acknowledge. Sits beside the PS/2 keyboard receiver in the keyboard-display top level and shares the same two bus lines. While a transfer is in flight it raises `rx_inhibit` so the receiver ignores bus activity.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame width and
// default cycle constants for a 25 MHz system clock.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS          = 8;
  localparam int unsigned PS2_INHIBIT_CYCLES_25M = 2500;   // 100 us
  localparam int unsigned PS2_TIMEOUT_CYCLES_25M = 50000;  // 2 ms

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } ps2_state_e;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one open-drain PS/2 line with falling-edge detect.
// Resets to all-ones so an idle (pulled-up) bus never produces a spurious fall.
module ps2_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic fall_c
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over the shared
// open-drain clock/data pair and checks the device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_25M,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_25M
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PS2_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx_done,
  output logic                     tx_err,
  output logic                     rx_inhibit,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_data_in,
  output logic                     ps2_clk_oe,
  output logic                     ps2_data_oe
);

  localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                       INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(PS2_DATA_BITS);

  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PS2_DATA_BITS - 1);

  ps2_state_e               state_q;
  ps2_state_e               state_d;
  logic [PS2_DATA_BITS-1:0] data_q;
  logic                     parity_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [CNT_W-1:0]         bit_cnt_d;
  logic [TMR_W-1:0]         timer_q;

  logic clk_lvl;
  logic clk_fall_c;
  logic data_lvl;
  logic data_fall_unused;

  logic accept_c;
  logic timed_out_c;
  logic device_phase_c;
  logic bus_idle_c;

  logic clk_oe_d;
  logic data_oe_d;
  logic ready_d;
  logic done_d;
  logic err_d;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (ps2_clk_in),
    .level   (clk_lvl),
    .fall_c  (clk_fall_c)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (ps2_data_in),
    .level   (data_lvl),
    .fall_c  (data_fall_unused)
  );

  assign accept_c       = (state_q == IDLE) && tx_valid && tx_ready;
  assign timed_out_c    = (timer_q == TMO_LAST);
  assign bus_idle_c     = clk_lvl && data_lvl;
  // Only device-clocked states; our own inhibit pulls clk low too.
  assign device_phase_c = (state_q == START)  || (state_q == DATA) ||
                          (state_q == PARITY) || (state_q == STOP) ||
                          (state_q == WAIT_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = INHIBIT;
          bit_cnt_d = '0;
        end
      end
      INHIBIT: if (timer_q == INH_LAST) state_d = REQ;
      REQ:     state_d = START;
      START: begin
        if (clk_fall_c) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else if (timed_out_c) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (clk_fall_c) begin
          if (bit_cnt_q == BIT_LAST) state_d = PARITY;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (timed_out_c) begin
          state_d = IDLE;
        end
      end
      PARITY: begin
        if (clk_fall_c)       state_d = STOP;
        else if (timed_out_c) state_d = IDLE;
      end
      STOP: begin
        if (clk_fall_c)       state_d = data_lvl ? IDLE : WAIT_IDLE;
        else if (timed_out_c) state_d = IDLE;
      end
      WAIT_IDLE: begin
        if (bus_idle_c || timed_out_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every pin/flag is registered
  always_comb begin
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    ready_d   = (state_d == IDLE);
    done_d    = (state_q == WAIT_IDLE) && bus_idle_c;
    err_d     = (state_q != IDLE) && (state_d == IDLE) && !done_d;
    case (state_d)
      INHIBIT: clk_oe_d  = 1'b1;
      REQ: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
      end
      START:   data_oe_d = 1'b1;
      DATA:    data_oe_d = ~data_q[bit_cnt_d];
      PARITY:  data_oe_d = ~parity_q;
      default: ;
    endcase
  end

  // Frame datapath and shared inhibit/timeout counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      if (accept_c) begin
        data_q   <= tx_data;
        parity_q <= odd_parity(tx_data);
      end
      if ((state_q == IDLE) || (state_d != state_q) || (device_phase_c && clk_fall_c))
        timer_q <= '0;
      else
        timer_q <= timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      rx_inhibit  <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_ready    <= ready_d;
      rx_inhibit  <= ~ready_d;
      tx_done     <= done_d;
      tx_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a wired-AND bus with a PS/2 device model
// clocking at a 10-cycle half-period.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_err_cyc = 0;
  logic [1:0] err_oe = 2'b11;
  logic [2:0] post_pulse = 3'b000;
  logic       pulse_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, timestamps and the bus state the cycle after a pulse
  always @(negedge clk) begin
    if (pulse_seen) post_pulse <= {tx_ready, ps2_clk_oe, ps2_data_oe};
    pulse_seen <= tx_done | tx_err;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
      err_oe       <= {ps2_clk_oe, ps2_data_oe};
    end
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Called in the first INHIBIT cycle; returns in the first START cycle
  task automatic to_start(output int n_inh, output int n_req, output int s_cyc);
    n_inh = 0;
    n_req = 0;
    while (ps2_clk_oe && !ps2_data_oe && n_inh < 100) begin
      n_inh++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && n_req < 100) begin
      n_req++;
      @(negedge clk);
    end
    s_cyc = cyc;
  endtask

  task automatic dev_clock(input int nfalls, input logic nack, output logic [10:0] obs);
    obs = '0;
    for (int i = 0; i < nfalls; i++) begin
      repeat (10) @(negedge clk);
      if (i == 10) dev_data = nack;
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      obs[i]  = ps2_data_oe;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic send_full(input string tag, input logic [7:0] d, input logic nack,
                           input logic [10:0] exp_obs);
    int ni, nr, sc, d0, e0;
    logic [10:0] obs;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(d);
    to_start(ni, nr, sc);
    check({tag, "_inhibit_len"}, ni, INH);
    check({tag, "_req_len"}, nr, 1);
    check({tag, "_start_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
    dev_clock(11, nack, obs);
    check({tag, "_data_oe"}, obs, exp_obs);
    repeat (10) @(negedge clk);
    check({tag, "_done"}, done_cnt - d0, nack ? 0 : 1);
    check({tag, "_err"}, err_cnt - e0, nack ? 1 : 0);
    check({tag, "_after_pulse"}, post_pulse, 3'b100);
  endtask

  initial begin
    int ni, nr, sc, d0, e0, k;
    logic [10:0] obs;

    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_inhibit", rx_inhibit, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_pulses", {tx_done, tx_err}, 2'b00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", tx_ready, 1);

    // 0xED: oe after falls 1..11 = 0,1,0,0,1,0,0,0,0,0,0
    send_full("ed", 8'hED, 1'b0, 11'h012);
    // 0x00: bits all driven low, parity 1 released
    send_full("zero", 8'h00, 1'b0, 11'h0FF);
    // 0x55 with device NACK
    send_full("nack", 8'h55, 1'b1, 11'h0AA);

    // Device never clocks
    e0 = err_cnt;
    d0 = done_cnt;
    accept(8'h3C);
    to_start(ni, nr, sc);
    check("tmo_rx_inhibit", rx_inhibit, 1);
    k = 0;
    while (err_cnt == e0 && k < 300) begin
      k++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_latency", last_err_cyc - sc, TMO);
    check("tmo_oe_at_err", err_oe, 2'b00);
    check("tmo_after_pulse", post_pulse, 3'b100);
    check("tmo_no_done", done_cnt - d0, 0);

    // Reset after fall 4 of 0x12 (oe for bits 0..3 = 1,0,1,1)
    e0 = err_cnt;
    d0 = done_cnt;
    accept(8'h12);
    to_start(ni, nr, sc);
    dev_clock(4, 1'b0, obs);
    check("rstmid_partial", obs, 11'h00D);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rstmid_ready", tx_ready, 1);
    check("rstmid_inhibit", rx_inhibit, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    send_full("f4", 8'hF4, 1'b0, 11'h10B);

    // 0xFF with tx_valid held high carrying 0xAA
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'hAA;
    to_start(ni, nr, sc);
    check("ff_inhibit_len", ni, INH);
    dev_clock(11, 1'b0, obs);
    check("ff_data_oe", obs, 11'h000);
    k = 0;
    while (!tx_ready && k < 100) begin
      k++;
      @(negedge clk);
    end
    check("ff_ready_back", tx_ready, 1);
    @(negedge clk);
    check("aa_accepted", {tx_ready, ps2_clk_oe}, 2'b01);
    tx_valid = 1'b0;
    check("ff_done", done_cnt - d0, 1);
    to_start(ni, nr, sc);
    check("aa_inhibit_len", ni, INH);
    dev_clock(11, 1'b0, obs);
    check("aa_data_oe", obs, 11'h055);
    repeat (10) @(negedge clk);
    check("aa_done", done_cnt - d0, 2);
    check("ffaa_err", err_cnt - e0, 0);

    check("done_err_exclusive", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
